bin_to_bcd_serial: RTL and testbench
====================================

Name: bin_to_bcd_serial

Overview:
- Sequential double-dabble converter: binary count from the frequency measurement path → packed BCD digits for the 7-segment/OLED digit renderer.
- Provides one digit per lookup through a combinational digit-select read port, plus leading-zero blanking.
- Sits between the gate-time counter and the 4-bit hex/BCD-to-segment decoder. The OLED scan logic steps `digit_sel` and feeds `digit_out` into the decoder.

Parameters:
- BIN_WIDTH, 24: width of the binary input value.
- DIGITS, 8: number of BCD digits produced.
- SEL_W, $clog2(DIGITS): width of `digit_sel` (derived, not overridden).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a conversion of `bin_in`; sampled only in IDLE.
- bin_in, input, BIN_WIDTH: binary value; captured on the accepting edge only.
- busy, output, 1: high from the accepting edge until return to IDLE.
- done, output, 1: single-cycle pulse when `bcd_out` is updated.
- overflow, output, 1: last conversion exceeded 10^DIGITS-1; held until the next done.
- bcd_out, output, 4*DIGITS: packed result, digit 0 (units) in bits [3:0]; registered.
- digit_sel, input, SEL_W: digit index for the read port, 0 = units.
- digit_out, output, 4: BCD digit selected by `digit_sel`; combinational from `bcd_out`.
- digit_blank, output, 1: selected digit is a leading zero; combinational.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, overflow=0, bcd_out=0, working registers=0. Reset mid-conversion aborts it; no done pulse follows.
- FSM states:
  - IDLE: busy=0. `start`=1 at an edge → capture `bin_in` into the shift register, clear the BCD accumulator and overflow accumulator, load bit counter = BIN_WIDTH, go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - Every BCD nibble ≥5 gets +3 (all nibbles in parallel).
    - Then the {bcd, bin} concatenation shifts left by 1.
    - The bit shifted out of the BCD MSB is ORed into the overflow accumulator.
    - Counter decrements. Exactly BIN_WIDTH SHIFT cycles, then go to DONE.
  - DONE: busy=1. `bcd_out` is loaded, `overflow` is loaded, done=1 for this single cycle, then go to IDLE.
- Latency: done is high in the cycle beginning BIN_WIDTH+1 edges after the edge that sampled start (25 cycles at default).
- Back-to-back: `start` held high continuously → next conversion accepted on the first IDLE edge after DONE. Throughput = BIN_WIDTH+2 cycles per conversion.
- `start` in SHIFT or DONE is ignored, not queued. `bin_in` changes after acceptance have no effect.
- Overflow: if the overflow accumulator is set at DONE, bcd_out = all nibbles 9 (saturate) and overflow=1. Otherwise bcd_out = accumulator and overflow=0.
- `bcd_out` and `overflow` are stable between done pulses. The display never sees partial results.
- `digit_sel` ≥ DIGITS → digit_out=0, digit_blank=1.
- digit_blank=1 when digit_sel≠0 and the selected digit plus all more-significant digits are 0. Units digit is never blanked, so value 0 displays "0".
- Combinational read port only; no registered dependency on `digit_sel`.

Test Plan:
- Reset release, then start with bin_in=0 → done after exactly 25 cycles; bcd_out=0x00000000, overflow=0; sweeping digit_sel 0..7 gives blank=0,1,1,1,1,1,1,1.
- bin_in=12345678 (decimal) → bcd_out=0x12345678, overflow=0. digit_sel=7 → digit_out=1, blank=0.
- bin_in=16777215 (max 24-bit) → bcd_out=0x16777215. Then bin_in=1000 → bcd_out=0x00001000; digit_sel=4 → blank=1, digit_sel=3 → digit_out=1, blank=0.
- DIGITS=4, BIN_WIDTH=16, bin_in=10000 → bcd_out=0x9999, overflow=1. Next conversion of 42 → bcd_out=0x0042, overflow=0.
- start=1 with bin_in=5, start pulsed again at cycles 3 and 10 with bin_in=7 → single done, bcd_out=5. busy continuous; next accepted start only after return to IDLE.
- rst_n asserted at cycle 12 of a conversion of 999 → outputs zero immediately and no done pulse. Fresh start of 999 → bcd_out=0x00000999 after 25 cycles.

Source files
------------

// File: rtl/bin_to_bcd_serial.sv
// Purpose : serial double-dabble binary-to-BCD converter with a digit read port
//           and leading-zero blanking for the frequency display.
// Latency : done rises BIN_WIDTH+1 edges after the edge that accepts start;
//           one conversion per BIN_WIDTH+2 cycles when start is held high.
// Backpressure: none. start is only sampled in IDLE and is ignored, not queued,
//           while busy. bcd_out/overflow hold their value between done pulses.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start, bin_in     : conversion request and binary value (captured on accept)
//   busy, done        : conversion in flight / single-cycle result-update pulse
//   overflow, bcd_out : saturation flag and packed BCD result (digit 0 = [3:0])
//   digit_sel         : digit index for the read port, 0 = units
//   digit_out         : selected BCD digit (combinational from bcd_out)
//   digit_blank       : selected digit is a leading zero (combinational)

module bin_to_bcd_serial #(
  parameter  int BIN_WIDTH = 24,
  parameter  int DIGITS    = 8,
  localparam int SEL_W     = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  input  logic [SEL_W-1:0]      digit_sel,
  output logic [3:0]            digit_out,
  output logic                  digit_blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 ovf_acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overflow_q;
  logic [BCD_W-1:0]     bcd_out_q;

  // Next working-register values for one SHIFT step.
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_shift_d;
  logic [BIN_WIDTH-1:0] bin_shift_d;
  logic                 ovf_shift_d;

  // One double-dabble step: every nibble >= 5 gets +3 in parallel, then the
  // whole {bcd, bin} word shifts left. A 1 leaving the top BCD nibble means
  // the value no longer fits in DIGITS digits, so it is sticky-ORed into the
  // overflow accumulator.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_shift_d, bin_shift_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
    ovf_shift_d = ovf_acc_q | bcd_adj[BCD_W-1];
  end

  // Control FSM. All outputs are registered here so the display side only
  // ever sees complete, stable results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_acc_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q     <= bin_in;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= CNT_W'(BIN_WIDTH);
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          bcd_q     <= bcd_shift_d;
          bin_q     <= bin_shift_d;
          ovf_acc_q <= ovf_shift_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          // cnt_q == 1 marks the last of BIN_WIDTH shift steps.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Out-of-range values saturate to all nines rather than showing a
          // truncated (and misleading) low-order result.
          if (ovf_acc_q) begin
            bcd_out_q <= {DIGITS{4'h9}};
          end else begin
            bcd_out_q <= bcd_q;
          end
          overflow_q <= ovf_acc_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd_out  = bcd_out_q;

  // Digit read port. A digit is a leading zero when it and every more
  // significant digit are zero; the units digit is exempt so a value of 0
  // still shows a single "0". Indices past the last digit read as blank zero.
  logic upper_nz;

  always_comb begin
    digit_out = 4'd0;
    upper_nz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (SEL_W'(i) == digit_sel) begin
        digit_out = bcd_out_q[4*i +: 4];
      end
      if ((i >= int'(digit_sel)) && (bcd_out_q[4*i +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
  end

  assign digit_blank = (digit_sel != '0) && !upper_nz;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Bench for bin_to_bcd_serial: an 8-digit/24-bit instance and a 4-digit/16-bit
// instance. Stimulus pushes expected results into per-instance queues; monitors
// pop and compare on every done pulse, including the cycle it arrives on.

module tb_bin_to_bcd_serial;

  localparam int BW8 = 24;
  localparam int D8  = 8;
  localparam int BW4 = 16;
  localparam int D4  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // 8-digit instance
  logic          start8;
  logic [BW8-1:0] bin8;
  logic          busy8, done8, ovf8;
  logic [4*D8-1:0] bcd8;
  logic [2:0]    sel8;
  logic [3:0]    digit8;
  logic          blank8;

  // 4-digit instance
  logic          start4;
  logic [BW4-1:0] bin4;
  logic          busy4, done4, ovf4;
  logic [4*D4-1:0] bcd4;
  logic [1:0]    sel4;
  logic [3:0]    digit4;
  logic          blank4;

  bin_to_bcd_serial #(.BIN_WIDTH(BW8), .DIGITS(D8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .overflow(ovf8), .bcd_out(bcd8),
    .digit_sel(sel8), .digit_out(digit8), .digit_blank(blank8)
  );

  bin_to_bcd_serial #(.BIN_WIDTH(BW4), .DIGITS(D4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .overflow(ovf4), .bcd_out(bcd4),
    .digit_sel(sel4), .digit_out(digit4), .digit_blank(blank4)
  );

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut8_unexpected_done actual=%h required=no_done", bcd8);
      end else begin
        e = q8.pop_front();
        chk("dut8_bcd", bcd8, e.bcd);
        chk("dut8_ovf", 32'(ovf8), 32'(e.ovf));
        chk("dut8_done_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut4_unexpected_done actual=%h required=no_done", bcd4);
      end else begin
        e = q4.pop_front();
        chk("dut4_bcd", 32'(bcd4), e.bcd);
        chk("dut4_ovf", 32'(ovf4), 32'(e.ovf));
        chk("dut4_done_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL dut8_idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic go8(input logic [BW8-1:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
    exp_t e;
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1;
    bin8   = v;
    @(posedge clk);
    #1;
    e.bcd = exp_bcd;
    e.ovf = exp_ovf;
    e.due = cyc + BW8 + 1;
    q8.push_back(e);
    start8 = 1'b0;
  endtask

  task automatic go4(input logic [BW4-1:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
    exp_t e;
    int n = 0;
    while (busy4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL dut4_idle_timeout actual=busy required=idle");
    end
    @(negedge clk);
    start4 = 1'b1;
    bin4   = v;
    @(posedge clk);
    #1;
    e.bcd = exp_bcd;
    e.ovf = exp_ovf;
    e.due = cyc + BW4 + 1;
    q4.push_back(e);
    start4 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q4.size() != 0 || busy8 || busy4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=q8:%0d,q4:%0d required=0,0", q8.size(), q4.size());
    end
    @(negedge clk);
  endtask

  task automatic dig8(input int sel, input logic [3:0] eo, input logic eb);
    sel8 = 3'(sel);
    #1;
    chk($sformatf("digit_out_sel%0d", sel), 32'(digit8), 32'(eo));
    chk($sformatf("digit_blank_sel%0d", sel), 32'(blank8), 32'(eb));
  endtask

  initial begin : main
    exp_t e;
    int   a;
    logic busy_ok;

    start8 = 1'b0; bin8 = '0; sel8 = '0;
    start4 = 1'b0; bin4 = '0; sel4 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_ovf8",  32'(ovf8),  32'd0);
    chk("rst_bcd8",  bcd8,       32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_bcd4",  32'(bcd4),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero: units shows "0", every other digit blanked
    go8(24'd0, 32'h0000_0000, 1'b0);
    drain();
    for (int i = 0; i < D8; i++) dig8(i, 4'd0, (i != 0));

    go8(24'd12345678, 32'h1234_5678, 1'b0);
    drain();
    dig8(7, 4'd1, 1'b0);
    dig8(4, 4'd4, 1'b0);
    dig8(0, 4'd8, 1'b0);

    go8(24'd16777215, 32'h1677_7215, 1'b0);
    drain();
    go8(24'd1000, 32'h0000_1000, 1'b0);
    drain();
    dig8(4, 4'd0, 1'b1);
    dig8(3, 4'd1, 1'b0);
    dig8(1, 4'd0, 1'b0);
    dig8(0, 4'd0, 1'b0);
    dig8(7, 4'd0, 1'b1);

    // 4-digit instance: overflow saturates, then clears on the next result
    go4(16'd10000, 32'h0000_9999, 1'b1);
    drain();
    go4(16'd42, 32'h0000_0042, 1'b0);
    drain();
    sel4 = 2'd2;
    #1;
    chk("dut4_digit_out_sel2", 32'(digit4), 32'd0);
    chk("dut4_blank_sel2", 32'(blank4), 32'd1);
    sel4 = 2'd1;
    #1;
    chk("dut4_digit_out_sel1", 32'(digit4), 32'd4);
    chk("dut4_blank_sel1", 32'(blank4), 32'd0);
    go4(16'd9999, 32'h0000_9999, 1'b0);
    drain();

    // start re-pulsed during SHIFT with a new value must be ignored
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 24'd5;
    @(posedge clk);
    #1;
    e.bcd = 32'h0000_0005;
    e.ovf = 1'b0;
    e.due = cyc + BW8 + 1;
    q8.push_back(e);
    start8  = 1'b0;
    bin8    = 24'd7;
    busy_ok = 1'b1;
    for (int k = 0; k <= BW8; k++) begin
      @(negedge clk);
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      start8 = (k == 3 || k == 10);
    end
    start8 = 1'b0;
    chk("busy_continuous", 32'(busy_ok), 32'd1);
    drain();

    // Back-to-back with start held: second accept on the first IDLE edge
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 24'd11;
    @(posedge clk);
    #1;
    a = cyc;
    bin8 = 24'd22;
    e.bcd = 32'h0000_0011; e.ovf = 1'b0; e.due = a + BW8 + 1;
    q8.push_back(e);
    e.bcd = 32'h0000_0022; e.ovf = 1'b0; e.due = a + (BW8 + 2) + BW8 + 1;
    q8.push_back(e);
    repeat (BW8 + 2) @(posedge clk);
    #1;
    start8 = 1'b0;
    drain();

    // Reset mid-conversion aborts: no done afterwards
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 24'd999;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_bcd8",  bcd8,       32'd0);
    chk("abort_ovf8",  32'(ovf8),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    go8(24'd999, 32'h0000_0999, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
